// File: rtl/rr_mux_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   - MODE_FIXED / MODE_RR : encodings for the RR parameter
//   - clog2()              : constant function that sizes the channel index
package rr_mux_pkg;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    // Smallest r with 2**r >= value, so clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Bus bundle for rr_mux_arbiter: N producer channels on one side and a
// single registered consumer port on the other.
//   in_valid  [N]        per-channel request
//   in_data   [N*WIDTH]  packed channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N]        one-hot-or-zero accept
//   out_valid            output register holds a word
//   out_data  [WIDTH]    registered selected word
//   out_sel   [SEL_W]    index of the channel that supplied out_data
//   out_ready            consumer takes the word this cycle
// Modports: slave = the arbiter, master = producers/consumer side.
interface rr_mux_arbiter_if
    import rr_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SEL_W = clog2(N)
);

    logic [N-1:0]       in_valid;
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_sel;
    logic               out_ready;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sel
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sel
    );

endinterface

// File: rtl/rr_priority_pick.sv
// Combinational winner selection for rr_mux_arbiter.
//   valid_i [N]      request vector
//   ptr_i   [SEL_W]  round-robin start index (ignored in fixed-priority mode)
//   grant_o [N]      one-hot winner, zero when no request
//   idx_o   [SEL_W]  encoded winner index
//   found_o          at least one request present
// Method: rotate the requests so ptr lands at bit 0, find the first set bit,
// then un-rotate the offset back into a channel index.
module rr_priority_pick
    import rr_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned RR    = MODE_RR,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic [N-1:0]     valid_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    // (a + b) mod N for a, b < N, so a single conditional subtract suffices.
    function automatic logic [SEL_W-1:0] wrap_add(input int unsigned a, input int unsigned b);
        int unsigned s;
        s = a + b;
        if (s >= N) begin
            s = s - N;
        end
        return SEL_W'(s);
    endfunction

    logic [SEL_W-1:0] base;
    logic [N-1:0]     rot;
    logic [SEL_W-1:0] off;
    logic             hit;

    always_comb begin
        base = (RR == MODE_RR) ? ptr_i : '0;

        rot = '0;
        for (int unsigned k = 0; k < N; k++) begin
            rot[k] = valid_i[wrap_add(32'(base), k)];
        end

        hit = 1'b0;
        off = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!hit && rot[k]) begin
                hit = 1'b1;
                off = SEL_W'(k);
            end
        end

        idx_o   = wrap_add(32'(base), 32'(off));
        found_o = hit;
        grant_o = '0;
        if (hit) begin
            grant_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel arbitrated mux with a single registered output stage.
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    rr_mux_arbiter_if.slave: per-channel valid/ready/data in,
//          registered valid/ready/data/sel out
// An internal arbiter (round-robin or fixed priority) picks one requesting
// channel whenever the output register is free; the winner's word is
// captured on the next edge together with its channel index.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned RR    = MODE_RR,
    parameter int unsigned SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    rr_mux_arbiter_if.slave  bus
);

    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;

    logic [N-1:0]     pick_grant;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             reg_free;
    logic             grant_en;
    logic [N-1:0]     in_ready;
    logic [WIDTH-1:0] sel_data;

    rr_priority_pick #(
        .N     (N),
        .RR    (RR),
        .SEL_W (SEL_W)
    ) u_pick (
        .valid_i (bus.in_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Free when empty or being drained this cycle; reset blocks every grant.
    assign reg_free = !out_valid_q || bus.out_ready;
    assign grant_en = reg_free && pick_found && !reset;
    assign in_ready = grant_en ? pick_grant : '0;

    // AND-OR select; the one-hot grant guarantees at most one slice passes.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            sel_data = sel_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{in_ready[i]}});
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (grant_en) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = pick_idx;
            if (RR == MODE_RR) begin
                ptr_d = (pick_idx == SEL_W'(N - 1)) ? '0 : pick_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            // Drain: data and sel keep their last values.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Parametrised N-channel, WIDTH-bit successor to the fixed 4:1 select mux.
- Selection is driven by an internal arbiter rather than an external select input.
- Each input channel has a valid/ready handshake. The winning channel's word is captured into a single registered output stage with its own valid/ready handshake.
- Sits between multiple producers and one shared consumer, for example a shared bus or a single-port sink.

Parameters:
N, 4, number of input channels; legal range 2..16.
WIDTH, 8, data width per channel.
RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins).
SEL_W, $clog2(N), width of the channel index. Derived; not to be overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  N  per-channel request; bit i = channel i has data.
in_data  input  N*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_ready  output  N  one-hot-or-zero grant/accept; bit i high = channel i's word is taken this cycle.
out_valid  output  1  output register holds a word.
out_data  output  WIDTH  registered selected word.
out_sel  output  SEL_W  index of the channel that supplied out_data.
out_ready  input  1  consumer accepts the word this cycle.

Behaviour:
- Clocking and reset
  - One clock; reset is synchronous and active-high. Clock port: clk. Reset port: reset.
  - Reset values: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
  - in_ready=0 for every cycle in which reset is high.
- Register state
  - The output register is "free" when out_valid==0 or out_ready==1.
- Grant (combinational, same cycle)
  - Grant only when the register is free and in_valid has at least one bit set.
  - In that case in_ready = one-hot of the winner g; otherwise in_ready = 0.
  - in_ready never asserts for a channel whose in_valid is 0.
  - in_ready never has more than one bit set.
- Winner selection
  - RR=1: first set bit of in_valid, searching upward from index ptr and wrapping N-1 -> 0.
  - RR=0: lowest set index; ptr is held at 0.
- Capture (next edge, after a grant)
  - out_data <= in_data[g]; out_sel <= g; out_valid <= 1.
  - RR=1: ptr <= (g==N-1) ? 0 : g+1.
  - ptr changes only on a grant.
- Latency: a word granted in cycle t appears on out_data/out_valid in cycle t+1.
- Throughput: one word per cycle. Same-cycle out_ready=1 plus a new grant replaces the register contents with no bubble.
- Drain: out_ready=1 and no grant -> out_valid <= 0; out_data and out_sel hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_sel and out_valid are stable, in_ready=0 and ptr is unchanged.
- Producer contract: producers must keep in_valid/in_data stable until granted. The block does not depend on this for correctness; a request withdrawn before grant is simply not selected.
- Fairness (RR=1): with all N channels continuously valid and out_ready=1, grants cycle 0,1,..,N-1,0,...; no channel waits more than N-1 grants.
- Reset mid-operation: any word held in the output register is discarded (out_valid=0 next cycle) and ptr returns to 0. No in_ready is issued during reset.
- Widths: in_data slicing uses the packed layout above. out_sel is zero-extended where N is not a power of two; values >= N never occur.

Decomposition:
- Shared package/header rr_mux_pkg:
  - CLOG2 helper constant function.
  - Localparams for mode encodings: MODE_FIXED=0, MODE_RR=1.
- One natural sub-module: rr_priority_pick (N, RR). Inputs: in_valid, ptr. Outputs: one-hot grant and encoded index g. Purely combinational; rotate, find-first, un-rotate.
- The top level contains:
  - the output register and handshake logic;
  - the ptr register;
  - the data select, as an AND-OR of in_data slices gated by the one-hot grant, mirroring the gate-level mux style.

Test Plan:
1. Reset with in_valid=4'b1111 -> in_ready=0, out_valid=0, out_data=0, out_sel=0 throughout reset. First cycle after reset: in_ready=4'b0001; next cycle out_sel=0.
2. RR=1, N=4, all channels valid with data 8'hA0..8'hA3, out_ready=1 -> one word per cycle, out_data sequence A0,A1,A2,A3,A0; out_sel 0,1,2,3,0 (wrap).
3. Channel 2 only valid, data 8'h5C, out_ready=0 for 3 cycles -> granted once (in_ready=4'b0100 for 1 cycle). out_data=5C held stable for 3 cycles. After out_ready=1 and in_valid=0: out_valid=0.
4. RR=0, in_valid=4'b1010 continuously, out_ready=1 -> channel 1 wins every cycle and channel 3 never gets in_ready. Same stimulus with RR=1 -> grants alternate 1,3,1,3.
5. ptr=3 after granting channel 2, then in_valid=4'b0011 -> search starts at 3 and wraps, so channel 0 wins (out_sel=0), then channel 1.
6. Reset asserted while out_valid=1, out_data=8'h77 -> next cycle out_valid=0, ptr=0. After reset release with in_valid=4'b0110: channel 1 wins first.
